// File: rtl/free_list_if.sv
// Allocate/release bus between the rename/commit stages and the free list.
// FREE_LIST_RECOVER_EN adds the commit-allocation and flush signals.
interface free_list_if #(
  parameter int PHY_REG_ADDR_WIDTH = 6
);
  logic                          alloc_first_i;
  logic                          alloc_second_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] free_list_rdata_first;
  logic [PHY_REG_ADDR_WIDTH-1:0] free_list_rdata_second;
  logic                          free_list_ready_o;
  logic                          release_first_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] release_tag_first_i;
  logic                          release_second_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] release_tag_second_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] free_count_o;
`ifdef FREE_LIST_RECOVER_EN
  logic                          commit_alloc_first_i;
  logic                          commit_alloc_second_i;
  logic                          flush_i;

  modport master (
    output alloc_first_i, alloc_second_i,
    output release_first_i, release_tag_first_i, release_second_i, release_tag_second_i,
    output commit_alloc_first_i, commit_alloc_second_i, flush_i,
    input  free_list_rdata_first, free_list_rdata_second, free_list_ready_o, free_count_o
  );
  modport slave (
    input  alloc_first_i, alloc_second_i,
    input  release_first_i, release_tag_first_i, release_second_i, release_tag_second_i,
    input  commit_alloc_first_i, commit_alloc_second_i, flush_i,
    output free_list_rdata_first, free_list_rdata_second, free_list_ready_o, free_count_o
  );
`else
  modport master (
    output alloc_first_i, alloc_second_i,
    output release_first_i, release_tag_first_i, release_second_i, release_tag_second_i,
    input  free_list_rdata_first, free_list_rdata_second, free_list_ready_o, free_count_o
  );
  modport slave (
    input  alloc_first_i, alloc_second_i,
    input  release_first_i, release_tag_first_i, release_second_i, release_tag_second_i,
    output free_list_rdata_first, free_list_rdata_second, free_list_ready_o, free_count_o
  );
`endif
endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: two allocations and two releases per cycle.
// Optional FREE_LIST_RECOVER_EN adds a retire head and flush-based recovery.
module free_list #(
  parameter int PHY_REG_NUM        = 64,
  parameter int ARCH_REG_NUM       = 32,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int FL_DEPTH           = 32
) (
  input logic       clk,
  input logic       rst,
  free_list_if.slave fl
);
  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0]              ptr_t;
  typedef logic [PHY_REG_ADDR_WIDTH-1:0] tag_t;

  if (FL_DEPTH != PHY_REG_NUM - ARCH_REG_NUM) begin : g_bad_depth
    $error("free_list: FL_DEPTH must equal PHY_REG_NUM - ARCH_REG_NUM");
  end

  tag_t mem [FL_DEPTH];
  ptr_t head, tail, head_nxt, head_p1, tail_p1, count, space, n_rel;
  logic [1:0] req;
  logic ready, rel_first, rel_second;
  logic wr0_en, wr1_en;
  tag_t wr0_data, wr1_data;

  assign count   = tail - head;
  assign space   = ptr_t'(FL_DEPTH) - count;
  assign head_p1 = head + ptr_t'(1);
  assign tail_p1 = tail + ptr_t'(1);
  assign req     = {1'b0, fl.alloc_first_i} + {1'b0, fl.alloc_second_i};

`ifdef FREE_LIST_RECOVER_EN
  ptr_t retire_head;
  assign ready = (count >= ptr_t'(req)) && !fl.flush_i;
`else
  assign ready = (count >= ptr_t'(req));
`endif

  always_comb begin
    head_nxt = head;
`ifdef FREE_LIST_RECOVER_EN
    if (fl.flush_i) head_nxt = retire_head;
    else if (ready) head_nxt = head + ptr_t'(req);
`else
    if (ready) head_nxt = head + ptr_t'(req);
`endif
  end

  // Tag 0 is never recycled; releases beyond the free space are dropped.
  assign rel_first  = fl.release_first_i  && (fl.release_tag_first_i  != '0);
  assign rel_second = fl.release_second_i && (fl.release_tag_second_i != '0);

  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = fl.release_tag_first_i;
    wr1_data = fl.release_tag_second_i;
    n_rel    = '0;
    if (space != '0) begin
      if (rel_first) begin
        wr0_en = 1'b1;
        n_rel  = ptr_t'(1);
        if (rel_second && space > ptr_t'(1)) begin
          wr1_en = 1'b1;
          n_rel  = ptr_t'(2);
        end
      end else if (rel_second) begin
        wr0_en   = 1'b1;
        wr0_data = fl.release_tag_second_i;
        n_rel    = ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= tag_t'(ARCH_REG_NUM + i);
      head <= '0;
      tail <= {1'b1, {IDX_W{1'b0}}};
    end else begin
      if (wr0_en) mem[tail[IDX_W-1:0]]    <= wr0_data;
      if (wr1_en) mem[tail_p1[IDX_W-1:0]] <= wr1_data;
      head <= head_nxt;
      tail <= tail + n_rel;
    end
  end

`ifdef FREE_LIST_RECOVER_EN
  always_ff @(posedge clk) begin
    if (!rst) retire_head <= '0;
    else retire_head <= retire_head
                        + ptr_t'({1'b0, fl.commit_alloc_first_i} + {1'b0, fl.commit_alloc_second_i});
  end
`endif

  assign fl.free_list_rdata_first  = mem[head[IDX_W-1:0]];
  assign fl.free_list_rdata_second = fl.alloc_first_i ? mem[head_p1[IDX_W-1:0]]
                                                      : mem[head[IDX_W-1:0]];
  assign fl.free_list_ready_o      = ready;
  assign fl.free_count_o           = tag_t'(count);
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: fixed vector table after reset, then
// queue-model-driven sequences (drain, empty+release, wrap, tag-0, overflow, recovery).
module tb_free_list;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  free_list_if #(.PHY_REG_ADDR_WIDTH(6)) fl ();
  free_list dut (.clk(clk), .rst(rst), .fl(fl));

  int tests  = 0;
  int failed = 0;

  typedef struct {
    bit a1, a2, r1; int t1; bit r2; int t2;
    bit rdy; int cnt, f, s;
  } vec_t;

  typedef struct {
    bit rdy; int cnt, f, s; bit chk_f, chk_s;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];
  int   fq[$];      // free tags, head first
  int   spec_q[$];  // allocated but not yet committed

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit a1, a2, r1, input int t1, input bit r2, input int t2,
                       input bit c1, c2, fls);
    fl.alloc_first_i        = a1;
    fl.alloc_second_i       = a2;
    fl.release_first_i      = r1;
    fl.release_tag_first_i  = 6'(t1);
    fl.release_second_i     = r2;
    fl.release_tag_second_i = 6'(t2);
`ifdef FREE_LIST_RECOVER_EN
    fl.commit_alloc_first_i  = c1;
    fl.commit_alloc_second_i = c2;
    fl.flush_i               = fls;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    fq.delete();
    spec_q.delete();
    for (int i = 0; i < 32; i++) fq.push_back(32 + i);
  endtask

  // One model-checked cycle; recovery inputs are only meaningful with the macro defined.
  task automatic step(input bit a1, a2, r1, input int t1, input bit r2, input int t2,
                      input bit c1 = 0, input bit c2 = 0, input bit fls = 0);
    exp_t e, g;
    int cnt, req, sp;
    bit rdy;
    @(negedge clk);
    drive(a1, a2, r1, t1, r2, t2, c1, c2, fls);
    cnt = fq.size();
    req = int'(a1) + int'(a2);
    rdy = (cnt >= req) && !fls;
    e.rdy   = rdy;
    e.cnt   = cnt;
    e.chk_f = cnt > 0;
    e.f     = (cnt > 0) ? fq[0] : 0;
    e.chk_s = a1 ? (cnt > 1) : (cnt > 0);
    e.s     = a1 ? ((cnt > 1) ? fq[1] : 0) : e.f;
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    check("ready", int'(fl.free_list_ready_o), int'(g.rdy));
    check("count", int'(fl.free_count_o), g.cnt);
    if (g.chk_f) check("rdata_first", int'(fl.free_list_rdata_first), g.f);
    if (g.chk_s) check("rdata_second", int'(fl.free_list_rdata_second), g.s);
    @(posedge clk);
    sp = 32 - cnt;
    if (fls) begin
      for (int i = spec_q.size() - 1; i >= 0; i--) fq.push_front(spec_q[i]);
      spec_q.delete();
    end else if (rdy) begin
      for (int i = 0; i < req; i++) spec_q.push_back(fq.pop_front());
    end
    for (int i = 0; i < int'(c1) + int'(c2); i++)
      if (spec_q.size() > 0) void'(spec_q.pop_front());
    if (r1 && t1 != 0 && sp > 0) begin fq.push_back(t1); sp--; end
    if (r2 && t2 != 0 && sp > 0) fq.push_back(t2);
  endtask

  initial begin
    vec_t v;
    //          a1 a2 r1 t1 r2 t2 rdy cnt  f   s
    vecs[0] = '{0, 0, 0, 0, 0, 0, 1, 32, 32, 32};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 1, 32, 32, 33};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 1, 31, 33, 33};
    vecs[3] = '{1, 1, 0, 0, 0, 0, 1, 31, 33, 34};
    vecs[4] = '{0, 1, 0, 0, 0, 0, 1, 29, 35, 35};
    vecs[5] = '{0, 0, 1, 5, 1, 9, 1, 28, 36, 36};
    vecs[6] = '{0, 0, 1, 0, 1, 7, 1, 30, 36, 36};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 31, 36, 36};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.a1, v.a2, v.r1, v.t1, v.r2, v.t2, 0, 0, 0);
      #1;
      check($sformatf("vec%0d_ready", i), int'(fl.free_list_ready_o), int'(v.rdy));
      check($sformatf("vec%0d_count", i), int'(fl.free_count_o), v.cnt);
      check($sformatf("vec%0d_first", i), int'(fl.free_list_rdata_first), v.f);
      check($sformatf("vec%0d_second", i), int'(fl.free_list_rdata_second), v.s);
      @(posedge clk);
    end

    // Drain to empty, stall, then refill from empty with no same-cycle bypass.
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 5, 1, 9);
    step(0, 0, 0, 0, 0, 0);

    // Steady alloc-2/release-2 traffic wraps both pointers several times.
    for (int k = 0; k < 40; k++)
      step(1, 1, 1, ((2 * k) % 62) + 1, 1, ((2 * k + 1) % 62) + 1);

    // Tag 0 is filtered; tag 7 must surface after the two older entries.
    step(0, 0, 1, 0, 1, 7);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Release into a full list is dropped.
    do_reset();
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 0, 0);

`ifdef FREE_LIST_RECOVER_EN
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("recover_count", int'(fl.free_count_o), 31);
    check("recover_first", int'(fl.free_list_rdata_first), 33);
`endif

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
